// File: rtl/mig_eval_pkg.sv
// Shared types and operand encoding for the MIG truth-table sequencer.
// MIG_EVAL_COMPL_EN adds a per-operand complement bit (OPW=5).
package mig_eval_pkg;

    localparam logic [3:0] OP_CONST0 = 4'd0;
    localparam logic [3:0] OP_X_BASE = 4'd1;
    localparam logic [3:0] OP_W_BASE = 4'd8;

`ifdef MIG_EVAL_COMPL_EN
    localparam int OPW = 5;

    typedef struct packed {
        logic       inv;
        logic [3:0] code;
    } operand_t;
`else
    localparam int OPW = 4;

    typedef struct packed {
        logic [3:0] code;
    } operand_t;
`endif

    typedef struct packed {
        operand_t c;
        operand_t b;
        operand_t a;
    } node_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EVAL,
        DONE
    } state_t;

    // True when the operand names a node that is not strictly earlier than slot.
    function automatic logic fwd_ref(input operand_t op, input int unsigned slot);
        return (op.code >= OP_W_BASE) && (32'(op.code - OP_W_BASE) >= slot);
    endfunction

endpackage

// File: rtl/mig_operand_mux.sv
// One operand selector: constant 0, primary input x0..x6 or node register w[j].
// Under MIG_EVAL_COMPL_EN the selected value is optionally complemented.
module mig_operand_mux
    import mig_eval_pkg::*;
#(
    parameter int MAX_NODES = 8
) (
    input  operand_t               op,
    input  logic [6:0]             x,
    input  logic [MAX_NODES-1:0]   w,
    output logic                   val
);

    logic raw;

    always_comb begin
        raw = 1'b0;
        if (op.code >= OP_W_BASE) begin
            for (int unsigned j = 0; j < MAX_NODES; j++) begin
                if (32'(op.code - OP_W_BASE) == j) raw = w[j];
            end
        end else if (op.code != OP_CONST0) begin
            raw = x[3'(op.code - OP_X_BASE)];
        end
    end

`ifdef MIG_EVAL_COMPL_EN
    assign val = raw ^ op.inv;
`else
    assign val = raw;
`endif

endmodule

// File: rtl/mig_eval_sequencer.sv
// Evaluates a programmed majority-inverter graph over all 128 input patterns,
// one node per cycle through a shared MAJ3. MIG_EVAL_COMPL_EN enables inversions.
module mig_eval_sequencer
    import mig_eval_pkg::*;
#(
    parameter int MAX_NODES = 8,
    parameter int NODE_W    = $clog2(MAX_NODES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [NODE_W-1:0]  prog_addr,
    input  logic [OPW*3-1:0]   prog_data,
    input  logic [NODE_W:0]    num_nodes,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [127:0]       tt
);

    state_t                 state;
    node_t                  prog [MAX_NODES];
    logic [NODE_W:0]        n_r;
    logic [NODE_W-1:0]      k;
    logic [6:0]             p;
    logic [MAX_NODES-1:0]   w;
    logic                   illegal;
    logic                   va, vb, vc, maj;
    node_t                  cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_NODES; i++) prog[i] <= '0;
        end else if (prog_we && state == IDLE && 32'(prog_addr) < MAX_NODES) begin
            prog[prog_addr] <= node_t'(prog_data);
        end
    end

    always_comb begin
        illegal = (n_r == '0) || (32'(n_r) > MAX_NODES);
        for (int unsigned s = 0; s < MAX_NODES; s++) begin
            if (s < 32'(n_r)) begin
                if (fwd_ref(prog[s].a, s) || fwd_ref(prog[s].b, s) || fwd_ref(prog[s].c, s))
                    illegal = 1'b1;
            end
        end
    end

    assign cur = prog[k];

    mig_operand_mux #(.MAX_NODES(MAX_NODES)) u_mux_a (.op(cur.a), .x(p), .w(w), .val(va));
    mig_operand_mux #(.MAX_NODES(MAX_NODES)) u_mux_b (.op(cur.b), .x(p), .w(w), .val(vb));
    mig_operand_mux #(.MAX_NODES(MAX_NODES)) u_mux_c (.op(cur.c), .x(p), .w(w), .val(vc));

    assign maj = (va & vb) | (va & vc) | (vb & vc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            tt    <= '0;
            p     <= '0;
            k     <= '0;
            n_r   <= '0;
            w     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r   <= num_nodes;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    tt  <= '0;
                    p   <= '0;
                    k   <= '0;
                    err <= illegal;
                    if (illegal) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    w[k] <= maj;
                    // The last node of each pattern is the function output.
                    if ((NODE_W+1)'(k) != n_r - 1'b1) begin
                        k <= k + NODE_W'(1);
                    end else begin
                        tt[p] <= maj;
                        k     <= '0;
                        if (p == 7'd127) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            p <= p + 7'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mig_eval_sequencer.sv
// Directed scoreboard bench for mig_eval_sequencer (default build and MIG_EVAL_COMPL_EN).
module tb_mig_eval_sequencer;
    import mig_eval_pkg::*;

    localparam int MAXN = 8;

    logic               clk;
    logic               rst_n;
    logic               prog_we;
    logic [2:0]         prog_addr;
    logic [OPW*3-1:0]   prog_data;
    logic [3:0]         num_nodes;
    logic               start;
    logic               busy;
    logic               done;
    logic               err;
    logic [127:0]       tt;

    typedef struct {
        logic [127:0] tt;
        logic         err;
        int           lat;
    } exp_t;

    exp_t               sb[$];
    logic [OPW*3-1:0]   model_prog [MAXN];
    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 n_fail   = 0;

    mig_eval_sequencer #(.MAX_NODES(MAXN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .num_nodes (num_nodes),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tt        (tt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] opx(input int i);
        return OPW'(i + 1);
    endfunction

    function automatic logic [OPW-1:0] opw(input int j);
        return OPW'(8 + j);
    endfunction

    function automatic logic [OPW*3-1:0] mk(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                             input logic [OPW-1:0] c);
        return {c, b, a};
    endfunction

    // Reference evaluation of the bench's own copy of the program.
    function automatic logic [127:0] model_tt(input int n);
        logic [127:0]   r;
        logic [7:0]     wv;
        logic [6:0]     xv;
        logic [2:0]     v;
        logic [OPW-1:0] op;
        logic [3:0]     code;
        r = '0;
        for (int pi = 0; pi < 128; pi++) begin
            xv = 7'(pi);
            wv = '0;
            for (int kn = 0; kn < n; kn++) begin
                for (int i = 0; i < 3; i++) begin
                    op   = model_prog[kn][i*OPW +: OPW];
                    code = op[3:0];
                    if (code == 4'd0)      v[i] = 1'b0;
                    else if (!code[3])     v[i] = xv[code[2:0] - 3'd1];
                    else                   v[i] = wv[code[2:0]];
`ifdef MIG_EVAL_COMPL_EN
                    v[i] = v[i] ^ op[4];
`endif
                end
                wv[kn] = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            end
            r[pi] = wv[n-1];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int a, input logic [OPW*3-1:0] d);
        prog_we   = 1'b1;
        prog_addr = 3'(a);
        prog_data = d;
        tick();
        prog_we = 1'b0;
        model_prog[a] = d;
    endtask

    // mode 0: plain run; 1: write+start pulses mid-run; 2: write in the start cycle
    task automatic run(input string tag, input logic [3:0] n, input logic [127:0] exp_tt,
                       input logic exp_err, input int exp_lat, input int mode);
        exp_t e;
        int   cyc;
        logic got;
        sb.push_back('{tt: exp_tt, err: exp_err, lat: exp_lat});
        num_nodes = n;
        start     = 1'b1;
        if (mode == 2) begin
            prog_we   = 1'b1;
            prog_addr = 3'd0;
            prog_data = mk(opx(0), opx(1), '0);
            model_prog[0] = prog_data;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 2000) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                start   = 1'b0;
                prog_we = 1'b0;
                check({tag, "_busy_T1"}, 128'(busy), 128'(1'b1));
            end
            if (mode == 1 && cyc == 50) begin
                prog_we   = 1'b1;
                prog_addr = 3'd0;
                prog_data = mk(opx(0), opx(1), opx(2));
                start     = 1'b1;
            end
            if (mode == 1 && cyc == 51) begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 128'(got), 128'(1'b1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, 128'(cyc), 128'(e.lat));
            check({tag, "_err"}, 128'(err), 128'(e.err));
            check({tag, "_tt"}, tt, e.tt);
            check({tag, "_busy_at_done"}, 128'(busy), 128'(1'b0));
        end
        tick();
        check({tag, "_done_pulse"}, 128'(done), 128'(1'b0));
    endtask

    initial begin
        int   cyc;
        logic seen;
        rst_n = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        num_nodes = '0;
        start = 1'b0;
        for (int i = 0; i < MAXN; i++) model_prog[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_err", 128'(err), 128'(1'b0));
        check("rst_tt", tt, '0);

        write_slot(0, mk(opx(0), opx(1), opx(2)));
        run("maj3", 4'd1, {16{8'hE8}}, 1'b0, 130, 0);

        write_slot(0, mk(opx(0), opx(1), '0));
        run("and2", 4'd1, {16{8'h88}}, 1'b0, 130, 0);

        write_slot(0, mk(opx(6), opx(6), '0));
        write_slot(1, mk(opw(0), opw(0), '0));
        run("chain", 4'd2, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 1'b0, 258, 0);

        write_slot(0, mk(opx(0), opx(1), opx(2)));
        write_slot(1, mk(opx(3), opx(4), opw(0)));
        write_slot(2, mk(opw(1), opx(5), '0));
        write_slot(3, mk(opw(2), opx(6), opw(0)));
        run("four", 4'd4, model_tt(4), 1'b0, 514, 0);

        write_slot(0, mk(opw(0), opx(0), opx(1)));
        run("selfref", 4'd1, '0, 1'b1, 2, 0);
        write_slot(0, mk(opx(0), opx(1), opx(2)));
        run("zero_n", 4'd0, '0, 1'b1, 2, 0);
        run("over_n", 4'd9, '0, 1'b1, 2, 0);
        write_slot(1, mk(opw(1), opx(0), opx(0)));
        run("fwdref", 4'd2, '0, 1'b1, 2, 0);

        run("we_start", 4'd1, {16{8'h88}}, 1'b0, 130, 2);
        run("interfere", 4'd1, {16{8'h88}}, 1'b0, 130, 1);
        run("after_intf", 4'd1, {16{8'h88}}, 1'b0, 130, 0);

        num_nodes = 4'd1;
        start = 1'b1;
        for (cyc = 1; cyc <= 50; cyc++) begin
            tick();
            if (cyc == 1) start = 1'b0;
        end
        check("midrun_busy", 128'(busy), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(1'b0));
        check("midrst_tt", tt, '0);
        seen = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < MAXN; i++) model_prog[i] = '0;
        repeat (200) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", 128'(seen), 128'(1'b0));
        run("rst_slots", 4'd1, '0, 1'b0, 130, 0);

`ifdef MIG_EVAL_COMPL_EN
        write_slot(0, mk(opx(0) | OPW'(16), opx(1) | OPW'(16), OPW'(16)));
        run("nand", 4'd1, {16{8'h77}}, 1'b0, 130, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mig_eval_sequencer.md
# mig_eval_sequencer

Programmable sequencer that computes the 128-bit truth table of a 7-input function.
- The function is expressed as a majority-inverter graph (MIG) of up to MAX_NODES majority-of-3 nodes.
- A single shared MAJ3 unit evaluates one node per cycle for each of the 128 input patterns.
- The block sits beside the combinational classification networks and produces their reference truth tables on-chip for comparison and classification.

## Interface
Parameters:
- MAX_NODES, 8, number of program slots, which is also the maximum node count (≤8).
- NODE_W, $clog2(MAX_NODES), width of node indices.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program slot write strobe.
- prog_addr  in  NODE_W  slot index being written.
- prog_data  in  OPW*3  operands {c,b,a}; OPW=4 (5 with COMPL_EN).
- num_nodes  in  NODE_W+1  active node count, sampled at start.
- start  in  1  request evaluation (accepted only in IDLE).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  valid with done; program illegal.
- tt  out  128  truth table; bit p = f(x) where x0=p[0] … x6=p[6].

## Operation
- Operand code, low 4 bits: 0 = const 0; 1..7 = x0..x6; 8..15 = node w(code-8).
- Node k may only reference w(j) with j<k.
- A reference to j≥k, j≥num_nodes, or j≥MAX_NODES is illegal.
- Node value = MAJ(a,b,c). The output is the node num_nodes-1.
- States and transitions:
  - IDLE: start=1 → CHECK.
  - CHECK (1 cycle): scan all active slots combinationally. num_nodes==0, num_nodes>MAX_NODES or any illegal operand → DONE with err=1 and tt=0. Otherwise clear tt, p=0, k=0 → EVAL.
  - EVAL: each cycle compute node k for pattern p into node register w[k].
    - If k<n-1: k++.
    - Else: tt[p] ← result. If p==127 → DONE, else p++, k=0.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- tt holds its value until the next accepted start clears it in CHECK.
- tt is updated bit by bit during EVAL, so bits are valid only after done with err=0.
- prog_we while busy: ignored, and the slot is not written. prog_we in IDLE: written at the clock edge. prog_we and start in the same cycle: the write takes effect first, so start uses the new data.
- start while busy or in DONE: ignored.
- Reset:
  - busy=0, done=0, err=0, tt=0, state IDLE, p=0, k=0.
  - Program slots reset to 0, which is MAJ(0,0,0).
  - An asserted reset mid-evaluation aborts with no done.

## Timing
- Accepted start at edge T: busy=1 from T+1 (CHECK). EVAL spans T+2 … T+1+128·n.
- done=1 in cycle T+2+128·n (n=num_nodes). busy is 0 in that cycle.
- For an n=1 run started at T=0, done appears at cycle 130.
- Error path: done at T+2 with err=1.
- Registered outputs only. There is no combinational path from start to busy or done.
- Back-to-back operation: the earliest next start is accepted in the cycle after done.

## Configuration
- MIG_EVAL_COMPL_EN defined:
  - Each operand has a 5th bit, the MSB, which complements that operand (complemented edge), so OPW=5.
  - Operand code 0 with its complement bit set gives const 1.
- Not defined:
  - OPW=4, there are no inversions, and prog_data is 12 bits.
  - The only constant is 0, so the block evaluates pure majority networks.

## Structure
- Package mig_eval_pkg holds:
  - the operand-code constants (OP_CONST0, OP_X_BASE, OP_W_BASE);
  - the OPW localparam, conditional on the macro;
  - the state enum (IDLE, CHECK, EVAL, DONE);
  - the operand struct.
- Sub-module mig_operand_mux:
  - Selects an operand from {0, x[6:0], w[MAX_NODES-1:0]} with optional complement.
  - It is instantiated three times and feeds a single MAJ3 expression in the top module.

## Test plan
- Single-node program: n=1, node0=MAJ(x0,x1,x2). Expect tt={16{8'hE8}}, err=0, done at start+130.
- AND via constant: n=1, MAJ(x0,x1,const0). Expect tt={16{8'h88}}.
- Chained nodes:
  - n=2, node0=MAJ(x6,x6,0), node1=MAJ(w0,w0,0).
  - Expect tt=128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000 and done at start+258.
- Illegal programs:
  - node0 references w0: done at start+2 with err=1 and tt=0.
  - num_nodes=0 gives the same response.
- Interference during a run:
  - prog_we and start pulses asserted mid-run leave both the program and the run unchanged.
  - Asserting rst_n=0 at cycle 50 gives busy=0, tt=0 and no done pulse.
- With MIG_EVAL_COMPL_EN: n=1, MAJ(~x0,~x1,const1) (NAND). Expect tt={16{8'h77}}.
